fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage sitting directly downstream of the program counter. Each cycle it decides whether the PC may advance, issues the current PC to a synchronous-read instruction memory, and buffers returned instructions (with their PC) in a small FIFO toward decode over a valid/ready handshake. It also kills queued and in-flight fetches on a branch redirect.

## Interface
- ADDR_W, 5, PC / instruction-memory address width
- INSTR_W, 16, instruction width
- DEPTH, 2, output FIFO entries (power of two, ≥2)
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- pc  in  ADDR_W  current PC value from the program counter
- advance  out  1  drives the PC's `control`; PC updates (increment, or branch target if `doBranch`) at the next edge
- halt  in  1  suppress new fetches (flush still honoured)
- flush  in  1  redirect; asserted in the same cycle decode asserts `doBranch` to the PC
- imem_en  out  1  memory read strobe
- imem_addr  out  ADDR_W  memory read address, equals `pc`
- imem_rdata  in  INSTR_W  read data, valid exactly one cycle after `imem_en`
- out_valid  out  1  FIFO head valid
- out_ready  in  1  decode accepts head
- out_instr  out  INSTR_W  head instruction
- out_pc  out  ADDR_W  PC of head instruction
- fetch_count, stall_count  out  16 each  only with FETCH_STATS_EN

## Operation
- State: FIFO (count 0..DEPTH), `inflight` bit, `inflight_pc` register.
- pop = out_valid & out_ready & ~flush.
- space = (count + inflight − pop) < DEPTH.
- advance = reset_n & (flush | (~halt & space)).
- imem_en = advance & ~flush; `imem_addr` = `pc` (combinational).
- On imem_en edge: inflight←1, inflight_pc←pc; otherwise inflight←0.
- Cycle with inflight=1 and no flush: push {imem_rdata, inflight_pc} into FIFO.
- flush: FIFO emptied, in-flight response discarded (not pushed), no new request that cycle; advance=1 so PC loads the branch target at that edge. First fetch of the target occurs the following cycle.
- flush has priority over halt, pop and push. halt with no flush: advance=0, PC holds, in-flight data still pushed, FIFO still drains.
- Push and pop in the same cycle: legal, count unchanged.
- PC wrap 31→0 handled upstream; out_pc carries the wrapped value unchanged.
- Full FIFO: advance=0 until a pop frees space; space accounts for the in-flight entry, so the FIFO never overflows.

## Timing
- Reset (reset_n low, any time, async): count=0, inflight=0, out_valid=0, out_instr=0, out_pc=0, advance=0, imem_en=0, counters=0. Mid-operation reset drops all queued and in-flight data.
- First cycle after reset release with halt=0: imem_en=1, imem_addr=0.
- Latency: request in cycle t → data returns in t+1 → out_valid=1 in t+2.
- Throughput: 1 instruction/cycle sustained with out_ready held high and DEPTH≥2.
- Branch penalty: flush in cycle t → target request in t+1 → target instruction at output in t+3.

## Configuration
- FETCH_STATS_EN defined: `fetch_count` increments on each imem_en; `stall_count` increments on cycles with ~halt & ~flush & ~advance. Both saturate at 0xFFFF and clear on reset.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package `fetch_pkg`: default ADDR_W, INSTR_W, DEPTH, stat counter width 16, and a packed fetch-entry type {pc, instr}.
- One sub-module: `fetch_fifo` (parameterised sync FIFO holding fetch entries, with clear input for flush, count output). Issue/credit logic and counters live in `fetch_unit`.

## Test plan
- Reset release with halt=0 and out_ready=1, memory word at addr k = 0x1000+k: advance=1 from cycle 0, out_valid rises in cycle 2 with out_pc=0 and out_instr=0x1000, then one instruction per cycle with pc 1,2,3….
- out_ready=0 from cycle 0: exactly DEPTH entries (pc 0,1) queued; advance falls; PC holds at 2; no entry lost once out_ready returns.
- Flush in the cycle after pc=5 is issued, with target 20: entries for pc 4 and 5 are never output; next out_pc=20 appears three cycles after the flush.
- Fetch through the wrap: out_pc sequence 30,31,0,1 with correct instructions, no bubbles.
- halt for 3 cycles mid-stream: advance=0 and the PC stable; the in-flight instruction is still delivered; the stream resumes in order.
- reset_n pulsed low while the FIFO is full and a fetch is in flight: all outputs at reset values immediately; after release the stream restarts at pc 0; with FETCH_STATS_EN the counters read 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared widths, entry type and helpers for the instruction fetch stage.
// FETCH_STATS_EN (when defined) adds saturating fetch/stall counters to fetch_unit.
package fetch_pkg;
    localparam int FETCH_ADDR_W  = 5;
    localparam int FETCH_INSTR_W = 16;
    localparam int FETCH_DEPTH   = 2;
    localparam int STAT_W        = 16;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries; clear empties it in one cycle.
// Output data reads as zero whenever the FIFO is empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter type T     = fetch_entry_t,
    parameter int  DEPTH = FETCH_DEPTH
)(
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_clr,
    input  logic                         i_push,
    input  T                             i_data,
    input  logic                         i_pop,
    output T                             o_data,
    output logic                         o_valid,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_clr) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_valid = (r_count != '0);
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: credit-based PC advance, sync-read imem issue, output FIFO, flush on redirect.
// Define FETCH_STATS_EN to add the fetch_count / stall_count ports.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = FETCH_ADDR_W,
    parameter int INSTR_W = FETCH_INSTR_W,
    parameter int DEPTH   = FETCH_DEPTH
)(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [ADDR_W-1:0]  pc,
    output logic               advance,
    input  logic               halt,
    input  logic               flush,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc
`ifdef FETCH_STATS_EN
    ,
    output logic [STAT_W-1:0]  fetch_count,
    output logic [STAT_W-1:0]  stall_count
`endif
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic              r_inflight;
    logic [ADDR_W-1:0] r_inflight_pc;

    logic              w_pop;
    logic              w_push;
    logic              w_space;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W:0]    w_pending;
    entry_t            w_push_entry;
    entry_t            w_head;

    // The in-flight read already owns a FIFO slot, so it counts against space.
    assign w_pop     = out_valid & out_ready & ~flush;
    assign w_pending = {1'b0, w_count} + (CNT_W+1)'(r_inflight) - (CNT_W+1)'(w_pop);
    assign w_space   = (w_pending < (CNT_W+1)'(DEPTH));

    assign advance   = reset_n & (flush | (~halt & w_space));
    assign imem_en   = advance & ~flush;
    assign imem_addr = pc;

    assign w_push       = r_inflight & ~flush;
    assign w_push_entry = '{pc: r_inflight_pc, instr: imem_rdata};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_inflight <= imem_en;
            if (imem_en) r_inflight_pc <= pc;
        end
    end

    fetch_fifo #(
        .T     (entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (flush),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_valid (out_valid),
        .o_count (w_count)
    );

    assign out_instr = w_head.instr;
    assign out_pc    = w_head.pc;

`ifdef FETCH_STATS_EN
    logic [STAT_W-1:0] r_fetch_count;
    logic [STAT_W-1:0] r_stall_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (imem_en)                     r_fetch_count <= sat_inc(r_fetch_count);
            if (~halt & ~flush & ~advance)   r_stall_count <= sat_inc(r_stall_count);
        end
    end

    assign fetch_count = r_fetch_count;
    assign stall_count = r_stall_count;
`endif
endmodule
